data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
Two-port round-robin arbiter and sequencer that shares the single-ported 16-bit data memory between requester A (CPU load/store stage) and requester B (DMA/debug loader). It accepts one access per grant and drives the memory's address, write-data, write-enable and read-enable lines. It captures combinational read data into a per-requester register and flags out-of-range addresses. It sits between the datapath/debug logic and the data memory.

Parameters:
ADDR_W, 16, requester and memory address width
DATA_W, 16, data width
DEPTH, 8, number of implemented memory words; addresses >= DEPTH are out of range

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
a_req  in  1  requester A access request; held with a_we/a_addr/a_wdata stable until a_gnt sampled high
a_we  in  1  1 = write, 0 = read
a_addr  in  ADDR_W  access address
a_wdata  in  DATA_W  write data
a_gnt  out  1  combinational accept strobe; the transaction is taken at the edge where it is high
a_rvalid  out  1  one-cycle pulse: read data valid, or write completed
a_rdata  out  DATA_W  registered read data (0 after a write)
a_err  out  1  one-cycle pulse with a_rvalid when the address was out of range
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_err  same as A, for requester B
mem_access_addr  out  ADDR_W  to memory
mem_write_data  out  DATA_W  to memory
mem_write_en  out  1  to memory; memory writes on the rising edge
mem_read  out  1  to memory
mem_read_data  in  DATA_W  combinational read data from memory
busy  out  1  high while state is ACCESS

Behaviour:
- FSM has two states, IDLE and ACCESS. Reset state is IDLE.
- Reset values: last_grant=B, so A wins the first tie. All outputs are 0, including rdata registers, rvalid, err, gnt and all mem_* lines.
- IDLE:
  - gnt is asserted combinationally to at most one requester.
  - Only one requesting: grant it.
  - Both requesting: grant the one that is not last_grant.
  - At the edge with a gnt high: latch we/addr/wdata into the command registers, record the winner, set last_grant=winner, go to ACCESS.
- ACCESS (exactly one cycle), all mem_* lines driven from the command registers:
  - In range: mem_write_en=cmd_we, mem_read=~cmd_we.
  - Out of range: mem_write_en=0 and mem_read=0; no memory access occurs.
  - At the closing edge:
    - Write commits in memory.
    - Winner's rdata <= mem_read_data for an in-range read, else 0.
    - Winner's rvalid pulses high for the following cycle; err pulses together with it if out of range.
  - Next state is IDLE.
- No gnt is issued during ACCESS. Requests arriving then wait.
- Latency: request granted at edge N, memory access during cycle N..N+1, rvalid/rdata visible in cycle N+1..N+2.
- Throughput: one access per 2 cycles. Under continuous requests from both sides, grants alternate A, B, A, B.
- The non-winner's rdata holds its previous value. rvalid of both requesters is never high in the same cycle.
- In IDLE, mem_* outputs are all 0 (address and write data included).
- Asynchronous reset mid-ACCESS:
  - mem_write_en drops immediately, so the pending write is not committed.
  - rvalid is not issued.
  - FSM returns to IDLE.
- Requester dropping req before its gnt: no transaction, no state change.
- Address comparison is unsigned, full ADDR_W width. The memory itself uses only the low bits.

Test Plan:
- Reset, then A write addr 3 data 0xBEEF: a_gnt at edge 0, mem_write_en=1 and mem_access_addr=3 during next cycle, a_rvalid pulse; then A read addr 3 -> a_rdata=0xBEEF, a_err=0.
- A and B both request continuously for 4 grants -> grant order A, B, A, B; busy toggles 1,0 each cycle pair; never two rvalids together.
- B read addr 8 (DEPTH=8) -> mem_read=0 and mem_write_en=0 throughout, b_rvalid=1 with b_err=1, b_rdata=0.
- A write addr 5 data 0x1234, rst_n pulsed low during ACCESS -> outputs zero immediately, no a_rvalid; after reset, a read of addr 5 returns its pre-write value.
- B holds req while A is in ACCESS -> b_gnt stays 0 until the following IDLE cycle, then b_gnt=1 and B's transaction completes with correct data.
- A read after B wrote addr 1 data 0x00FF in the previous grant -> a_rdata=0x00FF, b_rdata unchanged.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-ported data memory between requester A (CPU) and B (DMA/debug).
// One access per grant: an IDLE cycle with a combinational grant, then one ACCESS cycle that drives the memory.
//
// state  | meaning
// IDLE   | mem lines quiet, grant offered to at most one requester
// ACCESS | command registers drive the memory for exactly one cycle
module data_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant_b;
    logic              cmd_we;
    logic              cmd_owner_b;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_in_range;
    logic [DATA_W-1:0] rdata_capture;

    // Full-width unsigned compare; the memory only decodes the low bits.
    assign cmd_in_range  = (cmd_addr < ADDR_W'(DEPTH));
    assign rdata_capture = (cmd_in_range && !cmd_we) ? mem_read_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (a_gnt || b_gnt) state_nxt = ACCESS;
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a_gnt           = 1'b0;
        b_gnt           = 1'b0;
        busy            = 1'b0;
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the requester that did not win last time goes first.
                a_gnt = a_req && (!b_req || last_grant_b);
                b_gnt = b_req && (!a_req || !last_grant_b);
            end
            ACCESS: begin
                busy            = 1'b1;
                mem_access_addr = cmd_addr;
                mem_write_data  = cmd_wdata;
                mem_write_en    = cmd_in_range && cmd_we;
                mem_read        = cmd_in_range && !cmd_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_b <= 1'b1;
            cmd_we       <= 1'b0;
            cmd_owner_b  <= 1'b0;
            cmd_addr     <= '0;
            cmd_wdata    <= '0;
            a_rvalid     <= 1'b0;
            a_rdata      <= '0;
            a_err        <= 1'b0;
            b_rvalid     <= 1'b0;
            b_rdata      <= '0;
            b_err        <= 1'b0;
        end else begin
            a_rvalid <= 1'b0;
            a_err    <= 1'b0;
            b_rvalid <= 1'b0;
            b_err    <= 1'b0;
            if (state == IDLE && (a_gnt || b_gnt)) begin
                cmd_we       <= b_gnt ? b_we    : a_we;
                cmd_addr     <= b_gnt ? b_addr  : a_addr;
                cmd_wdata    <= b_gnt ? b_wdata : a_wdata;
                cmd_owner_b  <= b_gnt;
                last_grant_b <= b_gnt;
            end
            if (state == ACCESS) begin
                if (cmd_owner_b) begin
                    b_rvalid <= 1'b1;
                    b_err    <= !cmd_in_range;
                    b_rdata  <= rdata_capture;
                end else begin
                    a_rvalid <= 1'b1;
                    a_err    <= !cmd_in_range;
                    a_rdata  <= rdata_capture;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a table of single transactions plus hand-written
// sequences for reset during ACCESS, continuous contention and a request waiting out an ACCESS.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [15:0] a_addr = '0, a_wdata = '0;
    logic        a_gnt, a_rvalid, a_err;
    logic [15:0] a_rdata;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [15:0] b_addr = '0, b_wdata = '0;
    logic        b_gnt, b_rvalid, b_err;
    logic [15:0] b_rdata;
    logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read, busy;

    logic        mem_load = 1'b1;
    logic [15:0] mem [8];

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_a_rdata = '0;
    logic [15:0] exp_b_rdata = '0;

    data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read(mem_read),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: preload 0x1000+i, then writes on the rising edge.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 8; i++) mem[i] <= 16'h1000 + 16'(i);
        end else if (mem_write_en) begin
            mem[mem_access_addr[2:0]] <= mem_write_data;
        end
    end
    assign mem_read_data = mem[mem_access_addr[2:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        sel_b;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    // One isolated transaction: grant in IDLE, one ACCESS cycle, then the response cycle.
    task automatic apply(input vec_t v);
        @(negedge clk);
        if (v.sel_b) begin
            b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
        end else begin
            a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
        end
        #1;
        chk("gnt_a", a_gnt, !v.sel_b);
        chk("gnt_b", b_gnt, v.sel_b);
        chk("idle_busy", busy, 0);
        chk("idle_mem", {mem_write_en, mem_read, mem_access_addr, mem_write_data}, 0);
        @(posedge clk); #1;
        a_req = 1'b0; b_req = 1'b0;
        a_addr = 16'h0bad; b_addr = 16'h0bad; a_wdata = '0; b_wdata = '0;
        #1;
        chk("acc_busy", busy, 1);
        chk("acc_nognt", {a_gnt, b_gnt}, 0);
        chk("acc_we", mem_write_en, v.we && !v.exp_err);
        chk("acc_rd", mem_read, !v.we && !v.exp_err);
        chk("acc_addr", mem_access_addr, v.addr);
        if (v.we) chk("acc_wdata", mem_write_data, v.wdata);
        @(posedge clk); #1;
        if (v.sel_b) exp_b_rdata = v.exp_rdata;
        else         exp_a_rdata = v.exp_rdata;
        chk("rvalid_a", a_rvalid, !v.sel_b);
        chk("rvalid_b", b_rvalid, v.sel_b);
        chk("err_a", a_err, !v.sel_b && v.exp_err);
        chk("err_b", b_err, v.sel_b && v.exp_err);
        chk("rdata_a", a_rdata, exp_a_rdata);
        chk("rdata_b", b_rdata, exp_b_rdata);
        chk("rsp_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 16'd3,      16'hBEEF, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'd3,      16'h0000, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'd2,      16'h0000, 16'h1002, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'd8,      16'h0000, 16'h0000, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 16'd1,      16'h00FF, 16'h0000, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 16'd1,      16'h0000, 16'h00FF, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 16'hFFFF,   16'h0000, 16'h0000, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 16'h0107,   16'h0000, 16'h0000, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 16'd7,      16'h0000, 16'h1007, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 16'd3,      16'h0000, 16'hBEEF, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err, busy,
                         mem_write_en, mem_read}, 0);
        chk("rst_rdata", {a_rdata, b_rdata}, 0);
        chk("rst_mem", {mem_access_addr, mem_write_data}, 0);
        @(negedge clk);
        mem_load = 1'b0;
        rst_n    = 1'b1;

        for (int i = 0; i < 10; i++) apply(vecs[i]);

        // Reset pulse in the middle of an A write to addr 5.
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'd5; a_wdata = 16'h1234;
        #1 chk("rst_seq_gnt", a_gnt, 1);
        @(posedge clk); #1;
        a_req = 1'b0; a_we = 1'b0;
        chk("rst_seq_we", mem_write_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_seq_we_drop", mem_write_en, 0);
        chk("rst_seq_busy", busy, 0);
        chk("rst_seq_addr", mem_access_addr, 0);
        chk("rst_seq_b_rdata", b_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_a_rdata = '0;
        exp_b_rdata = '0;
        @(posedge clk); #1;
        chk("rst_seq_no_rvalid", {a_rvalid, b_rvalid}, 0);
        apply('{1'b0, 1'b0, 16'd5, 16'h0000, 16'h1005, 1'b0});

        // A in ACCESS while B requests: B must wait for the next IDLE cycle.
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'd4;
        #1 chk("wait_a_gnt", a_gnt, 1);
        @(posedge clk); #1;
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'd6;
        #1;
        chk("wait_b_blocked", b_gnt, 0);
        chk("wait_busy", busy, 1);
        @(posedge clk); #1;
        chk("wait_b_gnt", b_gnt, 1);
        chk("wait_a_rvalid", a_rvalid, 1);
        chk("wait_a_rdata", a_rdata, 16'h1004);
        @(posedge clk); #1;
        b_req = 1'b0;
        chk("wait_b_rd", {mem_read, mem_access_addr}, {1'b1, 16'd6});
        @(posedge clk); #1;
        chk("wait_b_rvalid", {a_rvalid, b_rvalid}, 2'b01);
        chk("wait_b_rdata", b_rdata, 16'h1006);

        // Continuous contention right after reset: A first, then alternating.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'd0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'd2;
        for (int n = 0; n < 9; n++) begin
            #1;
            if (n % 2 == 0) begin
                chk("rr_busy", busy, 0);
                if (n < 8) begin
                    chk("rr_gnt_a", a_gnt, (n % 4) == 0);
                    chk("rr_gnt_b", b_gnt, (n % 4) == 2);
                end
                chk("rr_rvalid_a", a_rvalid, n == 2 || n == 6);
                chk("rr_rvalid_b", b_rvalid, n == 4 || n == 8);
            end else begin
                chk("rr_busy", busy, 1);
                chk("rr_nognt", {a_gnt, b_gnt}, 0);
                chk("rr_no_rvalid", {a_rvalid, b_rvalid}, 0);
            end
            if (n == 7) begin
                a_req = 1'b0; b_req = 1'b0;
            end
            @(negedge clk);
        end
        chk("rr_a_rdata", a_rdata, 16'h1000);
        chk("rr_b_rdata", b_rdata, 16'h1002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
